// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS fetch front end.
package mips_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Where the next PC comes from on an accepted instruction.
  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_JMP = 2'd2,
    SRC_EXC = 2'd3
  } src_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

  // A redirect target is only legal when word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Fixed-priority next-PC select: exception > jump > branch > sequential,
// plus an alignment check on the chosen jump/branch target.
module next_pc_select
  import mips_pkg::*;
(
  input  logic [31:0] exc_vector,
  input  logic [31:0] pc_plus4,
  input  logic        exception,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output src_e        src,
  output logic [31:0] target,
  output logic        misaligned
);

  // Priority encode; only jump/branch targets can be misaligned.
  always_comb begin
    src        = SRC_SEQ;
    target     = pc_plus4;
    misaligned = 1'b0;
    if (exception) begin
      src    = SRC_EXC;
      target = exc_vector;
    end else if (jump) begin
      src        = SRC_JMP;
      target     = jump_target;
      misaligned = is_misaligned(jump_target);
    end else if (branch_taken) begin
      src        = SRC_BR;
      target     = branch_target;
      misaligned = is_misaligned(branch_target);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the PC, drives the fetch handshake, picks the next PC
// on each accepted instruction and counts retired instructions.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  input  logic        halt,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        misaligned,
  output logic [31:0] instr_count,
  output logic        running
);

  state_e      state_q;
  logic [31:0] pc_q, epc_q, cnt_q;
  logic        mis_q;

  src_e        sel_src;
  logic [31:0] sel_target;
  logic        sel_mis;
  logic        accept;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = (state_q == FETCH) && imem_ready && !stall;

  next_pc_select u_sel (
    .exc_vector    (EXC_VECTOR),
    .pc_plus4      (pc_plus4),
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .src           (sel_src),
    .target        (sel_target),
    .misaligned    (sel_mis)
  );

  // FSM plus PC/epc/counter update; exceptions outside an accept are taken
  // immediately, and a misaligned redirect is turned into an exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0;
      cnt_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q <= FETCH;
          if (exception) begin
            pc_q  <= EXC_VECTOR;
            epc_q <= pc_q;
          end
        end
        FETCH: begin
          if (accept) begin
            if (sel_src == SRC_EXC) begin
              pc_q  <= EXC_VECTOR;
              epc_q <= pc_q;
            end else if (sel_mis) begin
              pc_q  <= EXC_VECTOR;
              epc_q <= pc_q;
              mis_q <= 1'b1;
            end else begin
              pc_q  <= sel_target;
              cnt_q <= cnt_q + 32'd1;
              // Halt only takes effect on a plain sequential retire.
              if (halt && sel_src == SRC_SEQ) state_q <= HALTED;
            end
          end else if (exception) begin
            pc_q  <= EXC_VECTOR;
            epc_q <= pc_q;
          end
        end
        HALTED: ;
        default: state_q <= BOOT;
      endcase
    end
  end

  // All fetch-side outputs come straight from registers.
  assign imem_req    = (state_q == FETCH);
  assign running     = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign epc         = epc_q;
  assign misaligned  = mis_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle MIPS core. It owns the PC register and fetches from instruction memory over a req/ready handshake. On each accepted instruction it selects the next PC from exception, jump, branch and sequential sources by fixed priority. It replaces the loose next-PC mux chain with one controller that also handles stall, halt, misaligned redirects and a retired-instruction count.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception or misaligned redirect.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  fetch request; high only in state FETCH.
- imem_addr  out  32  fetch address; always equals the PC register.
- imem_ready  in  1  instruction memory has accepted and returned the word this cycle.
- stall  in  1  datapath hold; blocks PC advance.
- branch_taken  in  1  branch resolved taken for the current instruction.
- branch_target  in  32  branch target address.
- jump  in  1  jump (J/JAL/JR) for the current instruction.
- jump_target  in  32  jump target address.
- exception  in  1  exception request; accepted in any state except HALTED.
- halt  in  1  current instruction is a halt.
- pc_plus4  out  32  PC + 4, wrapping modulo 2^32; the link value for JAL.
- epc  out  32  PC captured on exception entry.
- misaligned  out  1  one-cycle registered pulse when a redirect was converted to an exception.
- instr_count  out  32  retired-instruction count; wraps.
- running  out  1  high in FETCH.

## Operation
- States:
  - BOOT: entered on reset; no request; advances to FETCH after one clock.
  - FETCH: imem_req high.
  - HALTED: imem_req low; exited only by rst.
- Accept event: FETCH && imem_ready && !stall. Redirect and halt inputs are sampled only in the accept cycle; otherwise they are ignored.
- Next-PC priority on accept, highest first:
  1. exception → EXC_VECTOR.
  2. jump → jump_target.
  3. branch_taken → branch_target.
  4. Otherwise → pc_plus4.
- Misaligned redirect: if the selected jump or branch target has bits[1:0] ≠ 0:
  - PC ← EXC_VECTOR and epc ← current PC.
  - misaligned pulses high for one cycle.
  - The instruction does not retire.
- exception when no accept occurs (FETCH and ready low, FETCH and stall high, or BOOT):
  - Taken immediately: PC ← EXC_VECTOR, epc ← PC.
  - In BOOT, the state also advances to FETCH.
- exception in HALTED is ignored.
- Exception entry always writes epc ← current PC, the faulting or unfetched instruction.
- On accept with halt and no exception or redirect: PC ← pc_plus4, state → HALTED, and instr_count increments.
- instr_count increments on every accept except exception and misaligned cases. It wraps from FFFF_FFFF to 0.
- stall overrides imem_ready: the PC holds and imem_req stays high.

## Timing
- Reset values:
  - PC = RESET_PC, state = BOOT.
  - epc = 0, instr_count = 0, misaligned = 0.
  - imem_req = 0, running = 0.
- First request is asserted one clock after rst deasserts, with imem_addr = RESET_PC.
- Latency: in the accept cycle the next PC is selected combinationally. It is visible on imem_addr the next cycle, so a zero-wait memory sustains one instruction per clock.
- imem_addr, imem_req and running are decoded from registers only; they have no combinational path from inputs.
- pc_plus4 is combinational from the PC.
- Reset mid-fetch aborts the fetch immediately, with no retire and no count.
- Wrap-around: PC FFFF_FFFC sequential → 0000_0000.

## Structure
- Shared package `mips_pkg`:
  - state enum {BOOT, FETCH, HALTED}.
  - default RESET_PC and EXC_VECTOR constants.
  - next-PC source enum {SRC_SEQ, SRC_BR, SRC_JMP, SRC_EXC}.
- Sub-module `next_pc_select`: combinational priority encode and alignment check. It outputs the source, the target and a misaligned flag.
- The top level holds the FSM, PC, epc and counter registers.

## Test plan
- Reset release, memory always ready, no redirects: imem_addr reads 0, 0, 4, 8, C on consecutive clocks after reset; instr_count = 3 after the third accept.
- Accept at PC 0x10 with jump = 1, jump_target 0x40 and branch_taken = 1, branch_target 0x80: jump wins, next imem_addr = 0x40.
- imem_ready low for 3 cycles at PC 0x20, then a branch to 0x100 on the accept cycle: imem_addr holds 0x20 for 3 cycles, then 0x100; instr_count increments exactly once.
- Branch to 0x102 from PC 0x30: next PC = 0x80, epc = 0x30, misaligned pulses for one cycle, instr_count unchanged.
- exception while stalled at PC 0x44: PC = 0x80 and epc = 0x44 the next cycle; a later halt accept enters HALTED, imem_req stays 0, and exception is then ignored.
- Sequential fetch from PC FFFF_FFFC: next imem_addr = 0; rst asserted mid-FETCH → imem_req drops at once and PC = RESET_PC.
